// File: rtl/osc_scheduler.sv
// Two-oscillator wavetable scheduler: one shared table port, one lookup per
// oscillator per sample tick, amplitude scaling and a halved two-voice mix.
module osc_scheduler #(
  parameter int ACC_W  = 24,
  parameter int TBL_AW = 10,
  parameter int SMP_W  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_sample_tick,
  input  logic [7:0]              i_osc1_wave,
  input  logic [ACC_W-1:0]        i_osc1_freq,
  input  logic [15:0]             i_osc1_phase,
  input  logic [15:0]             i_osc1_amp,
  input  logic [7:0]              i_osc2_wave,
  input  logic [ACC_W-1:0]        i_osc2_freq,
  input  logic [15:0]             i_osc2_phase,
  input  logic [15:0]             i_osc2_amp,
  output logic                    o_tbl_req,
  output logic [1:0]              o_tbl_sel,
  output logic [TBL_AW-1:0]       o_tbl_addr,
  input  logic signed [SMP_W-1:0] i_tbl_data,
  output logic signed [SMP_W-1:0] o_sample,
  output logic                    o_sample_valid,
  output logic                    o_busy,
  output logic                    o_overrun
);

  typedef enum logic [2:0] {IDLE, ACC1, REQ1, MUL1, ACC2, REQ2, MUL2, MIX} state_t;

  state_t state, state_next;

  logic [7:0]              wave1, wave2;
  logic [ACC_W-1:0]        freq1, freq2, acc1, acc2;
  logic [15:0]             phase1, phase2, amp1, amp2;
  logic signed [SMP_W-1:0] contrib1, contrib2;
  logic [1:0]              held_sel;
  logic [TBL_AW-1:0]       held_addr;

  // The second half of the frame (ACC2..MUL2) works on oscillator 2.
  logic                    osc2_active;
  logic [7:0]              cur_wave;
  logic [ACC_W-1:0]        cur_acc;
  logic [15:0]             cur_phase, cur_amp;
  logic                    cur_silent;
  logic [1:0]              cur_sel;
  logic [TBL_AW-1:0]       req_addr;

  assign osc2_active = (state == ACC2) || (state == REQ2) || (state == MUL2);
  assign cur_wave    = osc2_active ? wave2  : wave1;
  assign cur_acc     = osc2_active ? acc2   : acc1;
  assign cur_phase   = osc2_active ? phase2 : phase1;
  assign cur_amp     = osc2_active ? amp2   : amp1;
  assign cur_silent  = (cur_wave == 8'd0) || (cur_wave > 8'd4);
  assign cur_sel     = cur_wave[1:0] - 2'd1;
  assign req_addr    = cur_acc[ACC_W-1 -: TBL_AW] + cur_phase[15 -: TBL_AW];

  // Signed 33-bit product; bits [31:16] are the floor-shifted Q0.16 result.
  logic signed [SMP_W+16:0] data_ext, amp_ext, product;
  logic signed [SMP_W-1:0]  scaled;
  logic signed [SMP_W:0]    mix_sum;

  assign data_ext = {{17{i_tbl_data[SMP_W-1]}}, i_tbl_data};
  assign amp_ext  = {{(SMP_W+1){1'b0}}, cur_amp};
  assign product  = data_ext * amp_ext;
  assign scaled   = product[SMP_W+15:16];
  assign mix_sum  = {contrib1[SMP_W-1], contrib1} + {contrib2[SMP_W-1], contrib2};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_sample_tick) state_next = ACC1;
      ACC1:    state_next = REQ1;
      REQ1:    state_next = MUL1;
      MUL1:    state_next = ACC2;
      ACC2:    state_next = REQ2;
      REQ2:    state_next = MUL2;
      MUL2:    state_next = MIX;
      MIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (state != IDLE);
    o_tbl_req  = ((state == REQ1) || (state == REQ2)) && !cur_silent;
    o_tbl_sel  = o_tbl_req ? cur_sel  : held_sel;
    o_tbl_addr = o_tbl_req ? req_addr : held_addr;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wave1          <= '0;
      wave2          <= '0;
      freq1          <= '0;
      freq2          <= '0;
      phase1         <= '0;
      phase2         <= '0;
      amp1           <= '0;
      amp2           <= '0;
      acc1           <= '0;
      acc2           <= '0;
      contrib1       <= '0;
      contrib2       <= '0;
      held_sel       <= '0;
      held_addr      <= '0;
      o_sample       <= '0;
      o_sample_valid <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      o_sample_valid <= 1'b0;
      o_overrun      <= i_sample_tick && (state != IDLE);
      if (o_tbl_req) begin
        held_sel  <= cur_sel;
        held_addr <= req_addr;
      end
      case (state)
        IDLE: if (i_sample_tick) begin
          wave1  <= i_osc1_wave;
          freq1  <= i_osc1_freq;
          phase1 <= i_osc1_phase;
          amp1   <= i_osc1_amp;
          wave2  <= i_osc2_wave;
          freq2  <= i_osc2_freq;
          phase2 <= i_osc2_phase;
          amp2   <= i_osc2_amp;
        end
        ACC1: acc1     <= acc1 + freq1;
        MUL1: contrib1 <= cur_silent ? '0 : scaled;
        ACC2: acc2     <= acc2 + freq2;
        MUL2: contrib2 <= cur_silent ? '0 : scaled;
        MIX: begin
          o_sample       <= mix_sum[SMP_W:1];
          o_sample_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_osc_scheduler.sv
// Randomised bench for osc_scheduler against a frame-level reference model
// built from plain arithmetic on oscillator snapshots.
module tb_osc_scheduler;

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic               i_sample_tick;
  logic [7:0]         w1, w2;
  logic [23:0]        f1, f2;
  logic [15:0]        p1, p2, a1, a2;
  logic               o_tbl_req;
  logic [1:0]         o_tbl_sel;
  logic [9:0]         o_tbl_addr;
  logic signed [15:0] tbl_data = 16'sd0;
  logic signed [15:0] o_sample;
  logic               o_sample_valid;
  logic               o_busy;
  logic               o_overrun;

  int compared   = 0;
  int mismatched = 0;

  logic        force_en  = 1'b0;
  logic [15:0] force_val = 16'h0000;

  int unsigned macc[2];
  logic [1:0]  mlast_sel;
  logic [9:0]  mlast_addr;
  logic [15:0] mlast_sample;

  osc_scheduler dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sample_tick(i_sample_tick),
    .i_osc1_wave(w1), .i_osc1_freq(f1), .i_osc1_phase(p1), .i_osc1_amp(a1),
    .i_osc2_wave(w2), .i_osc2_freq(f2), .i_osc2_phase(p2), .i_osc2_amp(a2),
    .o_tbl_req(o_tbl_req), .o_tbl_sel(o_tbl_sel), .o_tbl_addr(o_tbl_addr),
    .i_tbl_data(tbl_data), .o_sample(o_sample), .o_sample_valid(o_sample_valid),
    .o_busy(o_busy), .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [15:0] tbl_value(input logic [1:0] s, input logic [9:0] a);
    logic [31:0] t;
    if (force_en) return force_val;
    t = 32'(a) * 32'd97 + 32'(s) * 32'd20011;
    return t[15:0] ^ 16'h5A3C;
  endfunction

  // Table answers only in the cycle after a request; garbage otherwise.
  logic       seen_req;
  logic [1:0] seen_sel;
  logic [9:0] seen_addr;
  always begin
    @(negedge i_clk);
    seen_req  = o_tbl_req;
    seen_sel  = o_tbl_sel;
    seen_addr = o_tbl_addr;
    @(posedge i_clk);
    #1;
    if (seen_req) tbl_data = tbl_value(seen_sel, seen_addr);
    else          tbl_data = 16'($urandom);
  end

  function automatic longint floor_div(input longint num, input longint den);
    longint q;
    q = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    return q;
  endfunction

  function automatic logic [31:0] out_vec();
    return {o_tbl_req, o_tbl_sel, o_tbl_addr, o_sample, o_sample_valid, o_busy, o_overrun};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    if (obs !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus();
    w1 = 8'($urandom_range(0, 6));
    w2 = 8'($urandom_range(0, 6));
    f1 = 24'($urandom);
    f2 = 24'($urandom);
    p1 = 16'($urandom);
    p2 = 16'($urandom);
    a1 = 16'($urandom);
    a2 = 16'($urandom);
  endtask

  task automatic model_reset();
    macc[0]      = 0;
    macc[1]      = 0;
    mlast_sel    = 2'd0;
    mlast_addr   = 10'd0;
    mlast_sample = 16'd0;
  endtask

  task automatic pulse_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    checkOutput("reset_outputs", 64'(out_vec()), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_reset();
  endtask

  // Called at a negedge; the tick is sampled on the following posedge.
  task automatic run_frame(input int extra_at, input bit scramble);
    logic [7:0]  sw[2];
    logic [23:0] sf[2];
    logic [15:0] sp[2], sa[2];
    longint      c[2];
    longint      d;
    logic [1:0]  sel;
    logic [9:0]  addr;
    logic [15:0] exp_sample, samp7, samp9;
    logic [1:0]  sel8;
    logic [9:0]  addr8;
    int          exp_ev[$];
    int          obs_ev[$];
    int          busy_m, ovr_m, val_m, n_cmp;

    sw = '{w1, w2};
    sf = '{f1, f2};
    sp = '{p1, p2};
    sa = '{a1, a2};
    for (int n = 0; n < 2; n++) begin
      macc[n] = (macc[n] + 32'(sf[n])) & 32'hFFFFFF;
      if (sw[n] == 8'd0 || sw[n] > 8'd4) begin
        c[n] = 0;
      end else begin
        sel  = 2'(sw[n] - 8'd1);
        addr = 10'(((macc[n] >> 14) + 32'(sp[n] >> 6)) & 32'h3FF);
        exp_ev.push_back((n == 0 ? 1 : 4) * 4096 + int'(sel) * 1024 + int'(addr));
        d    = longint'(shortint'(tbl_value(sel, addr)));
        c[n] = floor_div(d * longint'(sa[n]), 65536);
        mlast_sel  = sel;
        mlast_addr = addr;
      end
    end
    exp_sample = 16'(floor_div(c[0] + c[1], 2));

    busy_m = 0; ovr_m = 0; val_m = 0;
    samp7 = 16'd0; samp9 = 16'd0; sel8 = 2'd0; addr8 = 10'd0;
    i_sample_tick = 1'b1;
    for (int idx = 0; idx < 10; idx++) begin
      @(negedge i_clk);
      if (idx == 0 || idx == extra_at + 1) i_sample_tick = 1'b0;
      if (idx == extra_at) i_sample_tick = 1'b1;
      if (o_tbl_req) obs_ev.push_back(idx * 4096 + int'(o_tbl_sel) * 1024 + int'(o_tbl_addr));
      busy_m |= int'(o_busy) << idx;
      ovr_m  |= int'(o_overrun) << idx;
      val_m  |= int'(o_sample_valid) << idx;
      if (idx == 7) samp7 = o_sample;
      if (idx == 8) begin sel8 = o_tbl_sel; addr8 = o_tbl_addr; end
      if (idx == 9) samp9 = o_sample;
      if (scramble && idx == 2) applyStimulus();
    end

    checkOutput("req_count", 64'(obs_ev.size()), 64'(exp_ev.size()));
    n_cmp = (obs_ev.size() < exp_ev.size()) ? obs_ev.size() : exp_ev.size();
    for (int i = 0; i < n_cmp; i++) checkOutput("req_event", 64'(obs_ev[i]), 64'(exp_ev[i]));
    checkOutput("busy_window", 64'(busy_m), 64'h07F);
    checkOutput("overrun_pulse", 64'(ovr_m), (extra_at >= 0) ? 64'(1 << (extra_at + 1)) : 64'd0);
    checkOutput("valid_pulse", 64'(val_m), 64'h080);
    checkOutput("sample", 64'(samp7), 64'(exp_sample));
    checkOutput("sample_hold", 64'(samp9), 64'(exp_sample));
    checkOutput("addr_hold", 64'({sel8, addr8}), 64'({mlast_sel, mlast_addr}));
    mlast_sample = exp_sample;
  endtask

  initial begin
    int vcnt;
    bit prev_scr;
    bit scr;
    int extra;

    i_rst_n = 1'b0;
    i_sample_tick = 1'b0;
    model_reset();
    applyStimulus();

    repeat (3) begin
      @(negedge i_clk);
      applyStimulus();
      i_sample_tick = 1'($urandom);
      checkOutput("reset_outputs", 64'(out_vec()), 64'd0);
    end
    i_rst_n = 1'b1;
    i_sample_tick = 1'b0;
    @(negedge i_clk);

    // All oscillators silent.
    applyStimulus();
    w1 = 8'd0; w2 = 8'd0; f1 = 24'd0; f2 = 24'd0;
    run_frame(-1, 1'b0);

    // Single full-scale oscillator on the sine table.
    w1 = 8'd1; f1 = 24'h004000; p1 = 16'h0000; a1 = 16'hFFFF; w2 = 8'd0;
    force_en = 1'b1; force_val = 16'h4000;
    run_frame(-1, 1'b0);

    // Both oscillators on the saw table returning the most negative sample.
    w1 = 8'd3; w2 = 8'd3; a1 = 16'h8000; a2 = 16'h8000;
    force_val = 16'h8000;
    run_frame(-1, 1'b0);
    force_en = 1'b0;

    // Early second tick, tick during MIX, and mid-frame input changes.
    applyStimulus();
    w1 = 8'd2;
    run_frame(3, 1'b0);
    run_frame(6, 1'b0);
    run_frame(-1, 1'b1);
    run_frame(-1, 1'b0);

    // Reset pulled during the first table request.
    applyStimulus();
    w1 = 8'd1;
    i_sample_tick = 1'b1;
    @(negedge i_clk);
    i_sample_tick = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    checkOutput("midreset_outputs", 64'(out_vec()), 64'd0);
    vcnt = 0;
    repeat (8) begin
      @(negedge i_clk);
      vcnt += int'(o_sample_valid);
    end
    checkOutput("midreset_valid", 64'(vcnt), 64'd0);
    i_rst_n = 1'b1;
    model_reset();
    @(negedge i_clk);
    w1 = 8'd1; f1 = 24'h004000; p1 = 16'h0000; w2 = 8'd0;
    run_frame(-1, 1'b0);

    // Accumulator wrap with a phase offset.
    pulse_reset();
    w1 = 8'd1; f1 = 24'h800000; p1 = 16'hC000; w2 = 8'd0;
    run_frame(-1, 1'b0);
    run_frame(-1, 1'b0);

    prev_scr = 1'b0;
    for (int it = 0; it < 30; it++) begin
      if (!prev_scr) applyStimulus();
      extra = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 6));
      scr   = ($urandom_range(0, 3) == 0);
      run_frame(extra, scr);
      prev_scr = scr;
      if ($urandom_range(0, 1) == 1) @(negedge i_clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
